booth_product_display: RTL

- Downstream consumer of the 4-bit sign-magnitude Booth multiplier product (7-bit word: bit 6 = sign, bits 5:0 = magnitude).
- Converts the magnitude to two BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Latches the result and drives a time-multiplexed 4-digit active-low seven-segment display (ones, tens, sign, blank) on the lab board.

---
 rtl/booth_pkg.sv | 41 ++++
 rtl/seg7_decoder.sv | 32 +++
 rtl/booth_product_display.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Items shared by the Booth product display block:
//   - conversion FSM state encoding
//   - product magnitude width and double-dabble iteration count
//   - active-low seven-segment patterns (gfedcba), including blank and minus
// -----------------------------------------------------------------------------
package booth_pkg;

  // Product magnitude width; 6 bits -> 0..63 -> two BCD digits
  localparam int MAG_W     = 6;
  // One shift per magnitude bit
  localparam int BCD_ITERS = MAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Segment patterns, bit order gfedcba, a 0 lights the segment
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;

  // Double-dabble correction for one BCD nibble: add 3 when the nibble is 5
  // or more so that the following left shift carries into the next digit.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational BCD digit to active-low seven-segment pattern.
// Ports:
//   bcd_i  [3:0]  BCD digit; codes 10..15 produce a blank pattern
//   seg_o  [6:0]  segments gfedcba, active-low
// -----------------------------------------------------------------------------
module seg7_decoder
  import booth_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_D0;
      4'd1:    seg_o = SEG_D1;
      4'd2:    seg_o = SEG_D2;
      4'd3:    seg_o = SEG_D3;
      4'd4:    seg_o = SEG_D4;
      4'd5:    seg_o = SEG_D5;
      4'd6:    seg_o = SEG_D6;
      4'd7:    seg_o = SEG_D7;
      4'd8:    seg_o = SEG_D8;
      4'd9:    seg_o = SEG_D9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/booth_product_display.sv
// -----------------------------------------------------------------------------
// booth_product_display
// Takes the sign-magnitude product of the Booth multiplier, converts the
// magnitude to two BCD digits with a sequential double-dabble FSM, latches the
// result and scans it onto a 4-digit active-low seven-segment display
// (slot 0 = ones, 1 = tens, 2 = sign, 3 = blank).
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   prod_in     product: [MAG_W] sign, [MAG_W-1:0] magnitude
//   prod_valid  one-cycle strobe qualifying prod_in (ignored while busy)
//   busy        conversion in progress
//   done        one-cycle pulse when new digits are latched
//   sign_out    latched sign
//   bcd_tens    latched tens digit
//   bcd_ones    latched ones digit
//   seg         segments gfedcba, active-low
//   an          digit enables, active-low, an[0] = rightmost
// -----------------------------------------------------------------------------
module booth_product_display #(
  parameter int SCAN_DIV = 50000,
  parameter int MAG_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W:0]   prod_in,
  input  logic             prod_valid,
  output logic             busy,
  output logic             done,
  output logic             sign_out,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  import booth_pkg::*;

  // Shift register layout: {tens[3:0], ones[3:0], binary[MAG_W-1:0]}
  localparam int SR_W   = 8 + MAG_W;
  localparam int ITER_W = 3;
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic              load_en;
  logic              shift_en;
  logic              latch_en;
  logic              iter_last;

  logic [SR_W-1:0]   sr_q, sr_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              sign_cap_q, sign_cap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (prod_valid) state_d = SHIFT;
      SHIFT:   if (iter_last)  state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    latch_en = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE:  load_en = prod_valid;
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      LATCH: begin
        latch_en = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign iter_last = (iter_q == ITER_W'(BCD_ITERS - 1));

  // ---------------------------------------------------------------------------
  // Double-dabble datapath
  // ---------------------------------------------------------------------------
  logic [SR_W-1:0] sr_adj;

  assign sr_adj[MAG_W-1:0] = sr_q[MAG_W-1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nibble
      assign sr_adj[MAG_W + 4*gi +: 4] = dabble_adjust(sr_q[MAG_W + 4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    sr_d       = sr_q;
    iter_d     = iter_q;
    sign_cap_d = sign_cap_q;
    if (load_en) begin
      sr_d       = {8'h00, prod_in[MAG_W-1:0]};
      iter_d     = '0;
      sign_cap_d = prod_in[MAG_W];
    end else if (shift_en) begin
      sr_d   = {sr_adj[SR_W-2:0], 1'b0};
      iter_d = iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      iter_q     <= '0;
      sign_cap_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      iter_q     <= iter_d;
      sign_cap_q <= sign_cap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched result; only written in LATCH so intermediate values never show
  // ---------------------------------------------------------------------------
  logic       sign_q, sign_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       done_q;

  always_comb begin
    sign_d = sign_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (latch_en) begin
      sign_d = sign_cap_q;
      tens_d = sr_q[SR_W-1 -: 4];
      ones_d = sr_q[SR_W-5 -: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      done_q <= latch_en;
    end
  end

  assign done     = done_q;
  assign sign_out = sign_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

  // ---------------------------------------------------------------------------
  // Display scan, free-running and independent of the FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       ones_seg;
  logic [6:0]       tens_seg;
  logic             mag_nonzero;

  seg7_decoder u_dec_ones (
    .bcd_i (ones_q),
    .seg_o (ones_seg)
  );

  seg7_decoder u_dec_tens (
    .bcd_i (tens_q),
    .seg_o (tens_seg)
  );

  // Negative zero keeps sign_out set but must not light the minus sign
  assign mag_nonzero = (tens_q != 4'd0) || (ones_q != 4'd0);

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'b0111;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = ones_seg;
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (tens_q == 4'd0) ? SEG_BLANK : tens_seg;
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = (sign_q && mag_nonzero) ? SEG_MINUS : SEG_BLANK;
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
